instr_prefetch_ir: RTL

//  Parametrised instruction register with a prefetch queue in front of it.
//  - Buffers up to DEPTH instruction words fetched from memory.
//  - Loads the head word into the IR when the control unit asserts IRin.
//  - Splits the IR into opcode/Rx/Ry fields.
//  - Flushes the queue and the IR on a taken branch.
//  - Sits between instruction memory and the processor control FSM.

---
 rtl/ir_pkg.sv | 22 ++
 rtl/iq_fifo_core.sv | 62 ++++++
 rtl/instr_prefetch_ir.sv | 80 ++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the instruction register slice: default field widths,
// opcode encodings and field positions of the 9-bit instruction word.
package ir_pkg;

  localparam int IW_DEF   = 9;
  localparam int OPW_DEF  = 3;
  localparam int REGW_DEF = 3;

  // Field positions for the default instruction format: III XXX YYY
  localparam int OP_MSB = IW_DEF - 1;
  localparam int RX_LSB = REGW_DEF;
  localparam int RY_LSB = 0;

  localparam logic [OPW_DEF-1:0] OP_MV   = 3'd0;
  localparam logic [OPW_DEF-1:0] OP_MVI  = 3'd1;
  localparam logic [OPW_DEF-1:0] OP_ADD  = 3'd2;
  localparam logic [OPW_DEF-1:0] OP_SUB  = 3'd3;
  localparam logic [OPW_DEF-1:0] OP_LD   = 3'd4;
  localparam logic [OPW_DEF-1:0] OP_ST   = 3'd5;
  localparam logic [OPW_DEF-1:0] OP_MVNZ = 3'd6;

endpackage

// File: rtl/iq_fifo_core.sv
// Prefetch queue storage: DEPTH-entry circular buffer with wrapping pointers
// (any DEPTH >= 2), occupancy count and full/empty flags. Updates on falling edge.
module iq_fifo_core #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(negedge Clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Flush keeps wr_ptr where it is and drops everything by catching rd_ptr up.
  always_ff @(negedge Clock) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch_ir.sv
// Instruction register fed by a prefetch queue, with empty-queue bypass,
// taken-branch flush and opcode/Rx/Ry field split. State changes on falling edge.
module instr_prefetch_ir
  import ir_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int DEPTH = 4,
  parameter int OPW   = OPW_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [IW-1:0]   InstrIn,
  input  logic            InstrValid,
  output logic            InstrReady,
  input  logic            IRin,
  input  logic            Flush,
  output logic [IW-1:0]   IR,
  output logic            IRValid,
  output logic [OPW-1:0]  Opcode,
  output logic [REGW-1:0] Rx,
  output logic [REGW-1:0] Ry,
  output logic [CW-1:0]   Count,
  output logic            Empty,
  output logic            Full
);

  // Handshake: a word transfers on a falling edge where InstrValid && InstrReady;
  // InstrReady depends only on occupancy, so a pop on the same edge cannot make room.
  logic          push_fire;
  logic          bypass;
  logic [IW-1:0] head;

  assign InstrReady = !Full;
  assign push_fire  = InstrValid && InstrReady;
  assign bypass     = IRin && Empty && push_fire;

  iq_fifo_core #(
    .W     (IW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .push    (push_fire && !bypass),
    .pop     (IRin && !Empty),
    .flush   (Flush),
    .wr_data (InstrIn),
    .head    (head),
    .count   (Count),
    .full    (Full),
    .empty   (Empty)
  );

  always_ff @(negedge Clock) begin
    if (!Resetn) begin
      IR      <= '0;
      IRValid <= 1'b0;
    end else if (Flush) begin
      IR      <= '0;
      IRValid <= 1'b0;
    end else if (IRin) begin
      if (!Empty) begin
        IR      <= head;
        IRValid <= 1'b1;
      end else if (push_fire) begin
        IR      <= InstrIn;
        IRValid <= 1'b1;
      end else begin
        IRValid <= 1'b0;
      end
    end
  end

  assign Opcode = IR[IW-1 -: OPW];
  assign Rx     = IR[2*REGW-1 -: REGW];
  assign Ry     = IR[REGW-1:0];

endmodule
